// File: rtl/jelly_data_buffer.sv
// jelly_data_buffer
// Single-clock valid/ready elastic buffer: DEPTH-entry RAM plus one registered
// first-word-fall-through output stage. The output register is part of the
// DEPTH-word capacity. Provides occupancy counts and a synchronous flush.
module jelly_data_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int PTR_WIDTH  = 4,
    parameter bit RESET_DATA = 1'b1
) (
    input  logic                  reset,
    input  logic                  clk,
    input  logic                  flush,

    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,

    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,

    output logic [PTR_WIDTH:0]    data_count,
    output logic [PTR_WIDTH:0]    free_count
);

    localparam int                DEPTH     = 1 << PTR_WIDTH;
    localparam logic [PTR_WIDTH:0] DEPTH_CNT = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0] ONE_CNT   = (PTR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;

    logic                  push;
    logic                  pop;
    logic                  ram_empty;
    logic                  out_load;
    logic                  ram_read;
    logic                  ram_write;
    logic [PTR_WIDTH:0]    count_next;

    // Handshake decode and routing of the incoming word (bypass vs. RAM).
    // The output register is always filled whenever anything is stored, so
    // the RAM is empty exactly when data_count is 0 or 1.
    always_comb begin
        push       = s_valid && s_ready;
        pop        = m_valid && m_ready;
        ram_empty  = (data_count[PTR_WIDTH:1] == '0);
        out_load   = !m_valid || pop;
        ram_read   = out_load && !ram_empty;
        ram_write  = push && !(out_load && ram_empty);
        count_next = data_count;
        if (push && !pop) begin
            count_next = data_count + ONE_CNT;
        end else if (pop && !push) begin
            count_next = data_count - ONE_CNT;
        end
    end

    // Storage RAM; deliberately not reset, only read when it holds live words.
    always_ff @(posedge clk) begin
        if (ram_write && !flush && !reset) begin
            mem[wr_ptr] <= s_data;
        end
    end

    // Pointers, output stage and occupancy; flush outranks push/pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            m_valid    <= 1'b0;
            s_ready    <= 1'b1;
            data_count <= '0;
            free_count <= DEPTH_CNT;
            if (RESET_DATA) begin
                m_data <= '0;
            end
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            m_valid    <= 1'b0;
            s_ready    <= 1'b1;
            data_count <= '0;
            free_count <= DEPTH_CNT;
            if (RESET_DATA) begin
                m_data <= '0;
            end
        end else begin
            if (ram_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (ram_read) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (out_load) begin
                m_valid <= ram_read || push;
                if (ram_read) begin
                    m_data <= mem[rd_ptr];
                end else if (push) begin
                    m_data <= s_data;
                end
            end
            data_count <= count_next;
            free_count <= DEPTH_CNT - count_next;
            s_ready    <= (count_next != DEPTH_CNT);
        end
    end

endmodule
